// File: rtl/indegree_table.sv
// indegree_table: per-node in-degree store between the edge decoder and
// topological_sort.
//   CLEAR : after reset, sweeps every entry to 0, one per cycle (MAX_NODES cycles).
//   BUILD : counts edge_valid/dst_node increments per node.
//   SERVE : 1-cycle-latency reads and decrement-in-place requests (indeg_node/indeg_dec).
// Read-modify-write uses a 2-stage pipeline: stage 0 reads and computes, stage 1 writes.
// Stage 1's pending result is forwarded into stage 0, so back-to-back updates to one node chain.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   table_ready                 high once the clear sweep has finished
//   edge_valid, dst_node        edge stream; increments entry[dst_node] in BUILD
//   decoding_done               pulse; BUILD -> SERVE
//   indeg_node, indeg_dec       read address / decrement request
//   indeg_degree                entry[indeg_node] of the previous cycle, post-decrement
//   overflow, underflow         sticky saturation flags
//   dropped_edges               edges seen while table_ready=0 (saturates at 2^NODE_WIDTH-1)
// Optional feature (macro INDEGREE_ZERO_COUNT_EN):
//   zero_count                  number of entries currently at 0
module indegree_table #(
  parameter int unsigned MAX_NODES  = 1024,
  parameter int unsigned NODE_WIDTH = $clog2(MAX_NODES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  table_ready,
  input  logic                  edge_valid,
  input  logic [NODE_WIDTH-1:0] dst_node,
  input  logic                  decoding_done,
  input  logic [NODE_WIDTH-1:0] indeg_node,
  input  logic                  indeg_dec,
  output logic [NODE_WIDTH-1:0] indeg_degree,
  output logic                  overflow,
  output logic                  underflow,
  output logic [NODE_WIDTH-1:0] dropped_edges
`ifdef INDEGREE_ZERO_COUNT_EN
  ,
  output logic [NODE_WIDTH:0]   zero_count
`endif
);

  localparam int unsigned ZC_W = NODE_WIDTH + 1;
  localparam logic [NODE_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [NODE_WIDTH-1:0] CLR_LAST = NODE_WIDTH'(MAX_NODES - 1);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_BUILD = 2'd1,
    ST_SERVE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [NODE_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  table_ready_q, table_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [NODE_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [NODE_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [NODE_WIDTH-1:0] indeg_degree_q, indeg_degree_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [NODE_WIDTH-1:0] dropped_q, dropped_d;
`ifdef INDEGREE_ZERO_COUNT_EN
  logic [ZC_W-1:0]       zero_count_q, zero_count_d;
`endif

  logic [NODE_WIDTH-1:0] mem_q [MAX_NODES];

  logic [NODE_WIDTH-1:0] rmw_addr_c;
  logic [NODE_WIDTH-1:0] rmw_cur_c;
  logic [NODE_WIDTH-1:0] rd_cur_c;
  logic                  mem_we_c;
  logic [NODE_WIDTH-1:0] mem_waddr_c;
  logic [NODE_WIDTH-1:0] mem_wdata_c;

  // Stage 0 reads: the RMW port follows the edge stream in BUILD and indeg_node in SERVE;
  // the debug/read port always follows indeg_node. Both see the not-yet-written stage 1 result.
  always_comb begin
    rmw_addr_c = (state_q == ST_SERVE) ? indeg_node : dst_node;
    rmw_cur_c  = (wr_en_q && (wr_addr_q == rmw_addr_c)) ? wr_data_q : mem_q[rmw_addr_c];
    rd_cur_c   = (wr_en_q && (wr_addr_q == indeg_node)) ? wr_data_q : mem_q[indeg_node];
  end

  // Next-state, RMW compute and single write-port arbitration.
  always_comb begin
    state_d        = state_q;
    clr_addr_d     = clr_addr_q;
    table_ready_d  = table_ready_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = rmw_addr_c;
    wr_data_d      = rmw_cur_c;
    indeg_degree_d = rd_cur_c;
    overflow_d     = overflow_q;
    underflow_d    = underflow_q;
    dropped_d      = dropped_q;
`ifdef INDEGREE_ZERO_COUNT_EN
    zero_count_d   = zero_count_q;
`endif
    mem_we_c       = wr_en_q;
    mem_waddr_c    = wr_addr_q;
    mem_wdata_c    = wr_data_q;

    unique case (state_q)
      ST_CLEAR: begin
        // The sweep owns the write port; no RMW is ever in flight here.
        mem_we_c    = 1'b1;
        mem_waddr_c = clr_addr_q;
        mem_wdata_c = '0;
        clr_addr_d  = clr_addr_q + NODE_WIDTH'(1);
        if (edge_valid && (dropped_q != CNT_MAX)) begin
          dropped_d = dropped_q + NODE_WIDTH'(1);
        end
        if (clr_addr_q == CLR_LAST) begin
          state_d       = ST_BUILD;
          table_ready_d = 1'b1;
          clr_addr_d    = '0;
`ifdef INDEGREE_ZERO_COUNT_EN
          zero_count_d  = ZC_W'(MAX_NODES);
`endif
        end
      end

      ST_BUILD: begin
        if (edge_valid) begin
          wr_en_d = 1'b1;
          if (rmw_cur_c == CNT_MAX) begin
            overflow_d = 1'b1;
          end else begin
            wr_data_d = rmw_cur_c + NODE_WIDTH'(1);
`ifdef INDEGREE_ZERO_COUNT_EN
            if (rmw_cur_c == '0) begin
              zero_count_d = zero_count_q - ZC_W'(1);
            end
`endif
          end
        end
        if (decoding_done) begin
          state_d = ST_SERVE;
        end
      end

      ST_SERVE: begin
        if (indeg_dec) begin
          wr_en_d = 1'b1;
          if (rmw_cur_c == '0) begin
            underflow_d = 1'b1;
          end else begin
            wr_data_d = rmw_cur_c - NODE_WIDTH'(1);
`ifdef INDEGREE_ZERO_COUNT_EN
            if (rmw_cur_c == NODE_WIDTH'(1)) begin
              zero_count_d = zero_count_q + ZC_W'(1);
            end
`endif
          end
          // Reader sees the post-decrement value in the same cycle it is written.
          indeg_degree_d = wr_data_d;
        end
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_CLEAR;
      clr_addr_q     <= '0;
      table_ready_q  <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      indeg_degree_q <= '0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      dropped_q      <= '0;
`ifdef INDEGREE_ZERO_COUNT_EN
      zero_count_q   <= '0;
`endif
    end else begin
      state_q        <= state_d;
      clr_addr_q     <= clr_addr_d;
      table_ready_q  <= table_ready_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      indeg_degree_q <= indeg_degree_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      dropped_q      <= dropped_d;
`ifdef INDEGREE_ZERO_COUNT_EN
      zero_count_q   <= zero_count_d;
`endif
    end
  end

  // Table storage; contents are not reset, the CLEAR sweep initialises them.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  assign table_ready   = table_ready_q;
  assign indeg_degree  = indeg_degree_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;
  assign dropped_edges = dropped_q;
`ifdef INDEGREE_ZERO_COUNT_EN
  assign zero_count    = zero_count_q;
`endif

endmodule

// File: tb/tb_indegree_table.sv
// Directed bench for indegree_table: a 1024-node instance (a_*) and a 16-node instance (b_*).
module tb_indegree_table;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_rst_n = 1'b0, a_edge_valid = 1'b0, a_decoding_done = 1'b0, a_indeg_dec = 1'b0;
  logic [9:0] a_dst_node = '0, a_indeg_node = '0;
  logic       a_table_ready, a_overflow, a_underflow;
  logic [9:0] a_indeg_degree, a_dropped_edges;

  logic       b_rst_n = 1'b0, b_edge_valid = 1'b0, b_decoding_done = 1'b0, b_indeg_dec = 1'b0;
  logic [3:0] b_dst_node = '0, b_indeg_node = '0;
  logic       b_table_ready, b_overflow, b_underflow;
  logic [3:0] b_indeg_degree, b_dropped_edges;
`ifdef INDEGREE_ZERO_COUNT_EN
  logic [10:0] a_zero_count;
  logic [4:0]  b_zero_count;
`endif

  indegree_table #(.MAX_NODES(1024)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .table_ready(a_table_ready),
    .edge_valid(a_edge_valid), .dst_node(a_dst_node), .decoding_done(a_decoding_done),
    .indeg_node(a_indeg_node), .indeg_dec(a_indeg_dec), .indeg_degree(a_indeg_degree),
    .overflow(a_overflow), .underflow(a_underflow), .dropped_edges(a_dropped_edges)
`ifdef INDEGREE_ZERO_COUNT_EN
    , .zero_count(a_zero_count)
`endif
  );

  indegree_table #(.MAX_NODES(16)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .table_ready(b_table_ready),
    .edge_valid(b_edge_valid), .dst_node(b_dst_node), .decoding_done(b_decoding_done),
    .indeg_node(b_indeg_node), .indeg_dec(b_indeg_dec), .indeg_degree(b_indeg_degree),
    .overflow(b_overflow), .underflow(b_underflow), .dropped_edges(b_dropped_edges)
`ifdef INDEGREE_ZERO_COUNT_EN
    , .zero_count(b_zero_count)
`endif
  );

  task automatic test_reset;
    a_rst_n = 1'b0; a_edge_valid = 1'b1; a_dst_node = 10'd9; a_indeg_node = 10'd9;
    repeat (3) @(negedge clk);
    checks++; if (a_table_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", a_table_ready); end
    checks++; if (a_indeg_degree !== 10'd0) begin errors++; $display("FAIL rst_degree got %0d exp 0", a_indeg_degree); end
    checks++; if (a_overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b exp 0", a_overflow); end
    checks++; if (a_underflow !== 1'b0) begin errors++; $display("FAIL rst_underflow got %b exp 0", a_underflow); end
    checks++; if (a_dropped_edges !== 10'd0) begin errors++; $display("FAIL rst_dropped got %0d exp 0", a_dropped_edges); end
  endtask

  // Edges held high through the whole sweep: 1024 drops saturate a 10-bit counter at 1023.
  task automatic test_clear_sweep;
    int cyc;
    a_rst_n = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!a_table_ready && cyc < 3000);
    a_edge_valid = 1'b0;
    checks++; if (cyc != 1024) begin errors++; $display("FAIL sweep_cycles got %0d exp 1024", cyc); end
    checks++; if (a_dropped_edges !== 10'd1023) begin errors++; $display("FAIL sweep_dropped got %0d exp 1023", a_dropped_edges); end
    @(negedge clk);
    checks++; if (a_indeg_degree !== 10'd0) begin errors++; $display("FAIL sweep_node9 got %0d exp 0", a_indeg_degree); end
  endtask

  task automatic test_build_forward;
    a_edge_valid = 1'b1; a_dst_node = 10'd5;
    repeat (3) @(negedge clk);
    a_dst_node = 10'd7; a_decoding_done = 1'b1;
    @(negedge clk);
    a_edge_valid = 1'b0; a_decoding_done = 1'b0; a_indeg_node = 10'd7;
    @(negedge clk);
    checks++; if (a_indeg_degree !== 10'd1) begin errors++; $display("FAIL fwd_node7 got %0d exp 1", a_indeg_degree); end
    a_indeg_node = 10'd5;
    @(negedge clk);
    checks++; if (a_indeg_degree !== 10'd3) begin errors++; $display("FAIL fwd_node5 got %0d exp 3", a_indeg_degree); end
  endtask

  task automatic test_serve_ignore;
    a_edge_valid = 1'b1; a_dst_node = 10'd5; a_decoding_done = 1'b1;
    @(negedge clk);
    a_edge_valid = 1'b0; a_decoding_done = 1'b0;
    @(negedge clk);
    checks++; if (a_indeg_degree !== 10'd3) begin errors++; $display("FAIL serve_edge_ignored got %0d exp 3", a_indeg_degree); end
    checks++; if (a_dropped_edges !== 10'd1023) begin errors++; $display("FAIL serve_no_drop got %0d exp 1023", a_dropped_edges); end
  endtask

  task automatic test_serve_dec;
    a_indeg_node = 10'd5; a_indeg_dec = 1'b1;
    @(negedge clk);
    checks++; if (a_indeg_degree !== 10'd2) begin errors++; $display("FAIL dec1 got %0d exp 2", a_indeg_degree); end
    @(negedge clk);
    checks++; if (a_indeg_degree !== 10'd1) begin errors++; $display("FAIL dec2 got %0d exp 1", a_indeg_degree); end
    @(negedge clk);
    checks++; if (a_indeg_degree !== 10'd0) begin errors++; $display("FAIL dec3 got %0d exp 0", a_indeg_degree); end
    checks++; if (a_underflow !== 1'b0) begin errors++; $display("FAIL dec3_underflow got %b exp 0", a_underflow); end
    @(negedge clk);
    checks++; if (a_indeg_degree !== 10'd0) begin errors++; $display("FAIL dec4 got %0d exp 0", a_indeg_degree); end
    checks++; if (a_underflow !== 1'b1) begin errors++; $display("FAIL dec4_underflow got %b exp 1", a_underflow); end
    a_indeg_dec = 1'b0; a_indeg_node = 10'd7;
    @(negedge clk);
    checks++; if (a_indeg_degree !== 10'd1) begin errors++; $display("FAIL dec_other_node got %0d exp 1", a_indeg_degree); end
  endtask

  // decoding_done pulsed during the sweep must not skip BUILD.
  task automatic b_sweep(input string tag);
    int cyc;
    b_rst_n = 1'b1; b_decoding_done = 1'b1;
    @(negedge clk);
    cyc = 1;
    b_decoding_done = 1'b0;
    while (!b_table_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc != 16) begin errors++; $display("FAIL %s_cycles got %0d exp 16", tag, cyc); end
    checks++; if (b_dropped_edges !== 4'd0) begin errors++; $display("FAIL %s_dropped got %0d exp 0", tag, b_dropped_edges); end
  endtask

  task automatic test_overflow;
    b_sweep("b_sweep");
    b_dst_node = 4'd2; b_edge_valid = 1'b1;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      if (i == 15) begin
        checks++; if (b_overflow !== 1'b0) begin errors++; $display("FAIL ovf_before got %b exp 0", b_overflow); end
      end
    end
    @(negedge clk);
    checks++; if (b_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", b_overflow); end
    b_edge_valid = 1'b0; b_indeg_node = 4'd2;
    @(negedge clk);
    checks++; if (b_indeg_degree !== 4'd15) begin errors++; $display("FAIL ovf_value got %0d exp 15", b_indeg_degree); end
  endtask

  task automatic test_reset_mid_build;
    b_edge_valid = 1'b1; b_dst_node = 4'd3; b_indeg_node = 4'd3; b_indeg_dec = 1'b1;
    repeat (2) @(negedge clk);
    b_edge_valid = 1'b0; b_indeg_dec = 1'b0;
    @(negedge clk);
    checks++; if (b_indeg_degree !== 4'd2) begin errors++; $display("FAIL build_read3 got %0d exp 2", b_indeg_degree); end
    b_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    b_sweep("b_resweep");
    @(negedge clk);
    checks++; if (b_indeg_degree !== 4'd0) begin errors++; $display("FAIL resweep_node3 got %0d exp 0", b_indeg_degree); end
    checks++; if (b_overflow !== 1'b0) begin errors++; $display("FAIL resweep_overflow got %b exp 0", b_overflow); end
    checks++; if (b_underflow !== 1'b0) begin errors++; $display("FAIL resweep_underflow got %b exp 0", b_underflow); end
    b_indeg_node = 4'd2;
    @(negedge clk);
    checks++; if (b_indeg_degree !== 4'd0) begin errors++; $display("FAIL resweep_node2 got %0d exp 0", b_indeg_degree); end
  endtask

`ifdef INDEGREE_ZERO_COUNT_EN
  task automatic test_zero_count;
    checks++; if (b_zero_count !== 5'd16) begin errors++; $display("FAIL zc_init got %0d exp 16", b_zero_count); end
    b_edge_valid = 1'b1; b_dst_node = 4'd2;
    @(negedge clk);
    b_dst_node = 4'd3;
    @(negedge clk);
    b_edge_valid = 1'b0; b_decoding_done = 1'b1;
    checks++; if (b_zero_count !== 5'd14) begin errors++; $display("FAIL zc_build got %0d exp 14", b_zero_count); end
    @(negedge clk);
    b_decoding_done = 1'b0; b_indeg_node = 4'd2; b_indeg_dec = 1'b1;
    @(negedge clk);
    checks++; if (b_zero_count !== 5'd15) begin errors++; $display("FAIL zc_dec2 got %0d exp 15", b_zero_count); end
    b_indeg_node = 4'd3;
    @(negedge clk);
    b_indeg_dec = 1'b0;
    checks++; if (b_zero_count !== 5'd16) begin errors++; $display("FAIL zc_dec3 got %0d exp 16", b_zero_count); end
  endtask
`endif

  initial begin
    test_reset;
    test_clear_sweep;
    test_build_forward;
    test_serve_ignore;
    test_serve_dec;
    test_overflow;
    test_reset_mid_build;
`ifdef INDEGREE_ZERO_COUNT_EN
    test_zero_count;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
